// File: rtl/field_cfg_loader_if.sv
// Bus between field_cfg_loader and its memories: the configuration ROM read
// port and the field memory write port (valid/ready).
// master: the loader side. slave: the memory side.
interface field_cfg_loader_if #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48,
  parameter int WORD_W  = 32
);
  localparam int WORDS = FIELD_W * FIELD_H / WORD_W;
  localparam int AW    = $clog2(WORDS);
  localparam int RAW   = $clog2(2 * WORDS);

  logic [RAW-1:0]    o_rom_addr;
  logic              o_rom_re;
  logic [WORD_W-1:0] i_rom_data;
  logic              o_fld_we;
  logic [AW-1:0]     o_fld_addr;
  logic [WORD_W-1:0] o_fld_wdata;
  logic              i_fld_ready;

  modport master (
    output o_rom_addr, o_rom_re, o_fld_we, o_fld_addr, o_fld_wdata,
    input  i_rom_data, i_fld_ready
  );

  modport slave (
    input  o_rom_addr, o_rom_re, o_fld_we, o_fld_addr, o_fld_wdata,
    output i_rom_data, i_fld_ready
  );
endinterface

// File: rtl/field_cfg_loader.sv
// Game of Life field configuration loader.
// Copies CFG_1 (ROM words 0..WORDS-1) or CFG_2 (ROM words WORDS..2*WORDS-1)
// into the field memory, row-major, one word per accepted write. A 2-entry
// buffer absorbs the 1-cycle ROM latency so write stalls never lose data.
// Optional macro FCL_CLEAR_ON_NO_REQ_EN: i_go with NO_REQ writes WORDS zero
// words instead of being ignored.
package defs;
  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;
endpackage

module field_cfg_loader #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48,
  parameter int WORD_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_go,
  input  defs::load_cfg_req_t   i_cfg_req,
  output logic                  o_is_loading,
  field_cfg_loader_if.master    bus
);
  localparam int WORDS = FIELD_W * FIELD_H / WORD_W;
  localparam int AW    = $clog2(WORDS);
  localparam int RAW   = $clog2(2 * WORDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [RAW-1:0]    base;
  logic [RAW-1:0]    rd_cnt;
  logic [AW-1:0]     wr_cnt;
  logic              in_flight;
  logic              clr;
  logic [WORD_W-1:0] mem [2];
  logic              head;
  logic [1:0]        count;

  logic              start_clr;
  logic              cfg_sel;
  logic              accept_go;
  logic              we;
  logic              re;
  logic              pop;
  logic              last_wr;
  logic [1:0]        occ;

  // Start decode: which requests launch a load while idle
  always_comb begin
`ifdef FCL_CLEAR_ON_NO_REQ_EN
    start_clr = (i_cfg_req == defs::NO_REQ);
`else
    start_clr = 1'b0;
`endif
    cfg_sel   = (i_cfg_req == defs::CFG_1) || (i_cfg_req == defs::CFG_2);
    accept_go = (state == IDLE) && i_go && (cfg_sel || start_clr);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: leave RUN when the final word is accepted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept_go) state_nx = RUN;
      RUN:  if (last_wr)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic and handshake decode.
  // Read throttle uses buffer occupancy after this cycle's pop, so a read is
  // issued every cycle while writes drain, yet the 2-entry buffer never
  // overflows when the write side stalls.
  always_comb begin
    o_is_loading = (state == RUN);
    we      = (state == RUN) && (clr || (count != 2'd0));
    pop     = we && bus.i_fld_ready && !clr;
    last_wr = we && bus.i_fld_ready && (wr_cnt == AW'(WORDS - 1));
    occ     = count - {1'b0, pop};
    re      = (state == RUN) && !clr && (rd_cnt < RAW'(WORDS)) &&
              ((occ == 2'd0) || ((occ == 2'd1) && !in_flight));
    bus.o_fld_we    = we;
    bus.o_fld_addr  = wr_cnt;
    bus.o_fld_wdata = (we && !clr) ? mem[head] : '0;
    bus.o_rom_re    = re;
    bus.o_rom_addr  = re ? (base + rd_cnt) : '0;
  end

  // Datapath: counters, base latch and the 2-entry ROM data buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      in_flight <= 1'b0;
      clr       <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      head      <= 1'b0;
      count     <= '0;
    end else begin
      in_flight <= re;
      if (accept_go) begin
        base   <= (i_cfg_req == defs::CFG_2) ? RAW'(WORDS) : '0;
        rd_cnt <= '0;
        wr_cnt <= '0;
        head   <= 1'b0;
        count  <= '0;
        clr    <= start_clr;
      end else begin
        if (re) rd_cnt <= rd_cnt + 1'b1;
        if (in_flight) mem[head ^ count[0]] <= bus.i_rom_data;
        if (pop) head <= ~head;
        count <= count + {1'b0, in_flight} - {1'b0, pop};
        if (we && bus.i_fld_ready && !last_wr) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end
endmodule
